// File: rtl/aq_dtu_cdc_pulse_arb_if.sv
// Scheduler-side bundle between the event sources and the shared pulse-CDC channel.
// The design takes the slave modport; the stimulus side takes master.
interface aq_dtu_cdc_pulse_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 5
);
  logic [N_REQ-1:0] req_pulse;
  logic             arb_en;
  logic [CNT_W-1:0] cfg_hold_cyc;
  logic             cdc_pulse;
  logic [ID_W-1:0]  cdc_id;
  logic             busy;
  logic [N_REQ-1:0] req_ovf;
  logic [N_REQ-1:0] pend;

  modport master (
    output req_pulse, arb_en, cfg_hold_cyc,
    input  cdc_pulse, cdc_id, busy, req_ovf, pend
  );
  modport slave (
    input  req_pulse, arb_en, cfg_hold_cyc,
    output cdc_pulse, cdc_id, busy, req_ovf, pend
  );
endinterface

// File: rtl/aq_dtu_cdc_pulse_arb.sv
// Round-robin scheduler sharing one pulse-CDC channel among N_REQ sources.
// Each grant fires one pulse and then holds the channel idle for H+1 cycles.
module aq_dtu_cdc_pulse_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 5
) (
  input  logic                     i_src_clk,
  input  logic                     i_src_rst,
  aq_dtu_cdc_pulse_arb_if.slave    io_arb
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_pend, r_ovf, w_gnt;
  logic [ID_W-1:0]  r_rr_ptr, r_id, w_gnt_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse, w_grant, w_busy;

  // Rotating search from r_rr_ptr; the first pending index wins.
  always_comb begin
    int              j;
    logic [ID_W-1:0] jj;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_grant   = 1'b0;
    j         = 0;
    jj        = '0;
    if (r_state == IDLE && io_arb.arb_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        j = int'(r_rr_ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        jj = ID_W'(j);
        if (!w_grant && r_pend[jj]) begin
          w_grant    = 1'b1;
          w_gnt[jj]  = 1'b1;
          w_gnt_idx  = jj;
        end
      end
    end
  end

  always_ff @(posedge i_src_clk) begin
    if (i_src_rst) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = HOLD;
      HOLD:    if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == HOLD);
  end

  // A request landing on its own grant cycle is re-queued, not flagged as overflow.
  always_ff @(posedge i_src_clk) begin
    if (i_src_rst) begin
      r_pend   <= '0;
      r_ovf    <= '0;
      r_pulse  <= 1'b0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_pend  <= (r_pend & ~w_gnt) | io_arb.req_pulse;
      r_ovf   <= io_arb.req_pulse & r_pend & ~w_gnt;
      r_pulse <= w_grant;
      if (w_grant) begin
        r_id     <= w_gnt_idx;
        r_cnt    <= io_arb.cfg_hold_cyc;
        r_rr_ptr <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign io_arb.cdc_pulse = r_pulse;
  assign io_arb.cdc_id    = r_id;
  assign io_arb.busy      = w_busy;
  assign io_arb.req_ovf   = r_ovf;
  assign io_arb.pend      = r_pend;
endmodule

// File: tb/tb_aq_dtu_cdc_pulse_arb.sv
// Directed scenarios plus random traffic against a timestamp-based model of the scheduler.
module tb_aq_dtu_cdc_pulse_arb;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aq_dtu_cdc_pulse_arb_if #(.N_REQ(N), .ID_W(IW), .CNT_W(CW)) arb_if ();

  aq_dtu_cdc_pulse_arb #(.N_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .i_src_clk (clk),
    .i_src_rst (rst),
    .io_arb    (arb_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Model: channel is free again H+2 cycles after a grant; busy spans grant+1 .. grant+1+H.
  logic [N-1:0] m_pend, e_ovf;
  int           m_ptr, cyc, m_free_at, m_busy_until, e_id;
  logic         e_pulse;

  initial begin
    m_pend = '0; e_ovf = '0; m_ptr = 0; cyc = 0;
    m_free_at = 0; m_busy_until = -1; e_id = 0; e_pulse = 1'b0;
  end

  task automatic step(input logic r, input logic [N-1:0] req, input logic en, input int h);
    logic [N-1:0] gnt;
    rst                 = r;
    arb_if.req_pulse    = req;
    arb_if.arb_en       = en;
    arb_if.cfg_hold_cyc = CW'(h);
    gnt = '0;
    if (r) begin
      m_pend = '0; m_ptr = 0; m_free_at = cyc + 1; m_busy_until = -1;
      e_pulse = 1'b0; e_id = 0; e_ovf = '0;
    end else begin
      e_pulse = 1'b0;
      if (cyc >= m_free_at && en && m_pend != '0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (gnt == '0 && m_pend[i]) gnt[i] = 1'b1;
          if (gnt[i] && !e_pulse) begin
            e_pulse = 1'b1; e_id = i; m_ptr = (i + 1) % N;
            m_free_at = cyc + h + 2; m_busy_until = cyc + 1 + h;
          end
        end
      end
      e_ovf  = req & m_pend & ~gnt;
      m_pend = (m_pend & ~gnt) | req;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("cdc_pulse", arb_if.cdc_pulse, e_pulse);
    chk("cdc_id", arb_if.cdc_id, e_id);
    chk("busy", arb_if.busy, cyc <= m_busy_until);
    chk("req_ovf", arb_if.req_ovf, e_ovf);
    chk("pend", arb_if.pend, m_pend);
  endtask

  task automatic idle(input int n, input logic en, input int h);
    for (int i = 0; i < n; i++) step(1'b0, '0, en, h);
  endtask

  initial begin
    logic         en;
    logic         r;
    logic [N-1:0] req;
    rst = 1'b1;
    arb_if.req_pulse = '0; arb_if.arb_en = 1'b0; arb_if.cfg_hold_cyc = '0;

    step(1'b1, '0, 1'b1, 6);
    step(1'b1, '0, 1'b1, 6);
    chk("rst_pulse", arb_if.cdc_pulse, 1'b0);
    chk("rst_pend", arb_if.pend, '0);

    // Single request: pend next cycle, pulse the cycle after, id 2, busy 7 cycles.
    idle(3, 1'b1, 6);
    step(1'b0, 4'b0100, 1'b1, 6);
    chk("t1_pend", arb_if.pend, 4'b0100);
    step(1'b0, '0, 1'b1, 6);
    chk("t1_pulse", arb_if.cdc_pulse, 1'b1);
    chk("t1_id", arb_if.cdc_id, 2);
    idle(12, 1'b1, 6);

    // All four at once, rr_ptr=3 now: order 3,0,1,2, pulses H+2 apart.
    step(1'b0, 4'b1111, 1'b1, 6);
    idle(36, 1'b1, 6);

    // Overflow while frozen, then release.
    step(1'b0, 4'b0010, 1'b0, 6);
    step(1'b0, 4'b0010, 1'b0, 6);
    chk("t4_ovf", arb_if.req_ovf, 4'b0010);
    step(1'b0, 4'b0101, 1'b0, 6);
    idle(20, 1'b0, 6);
    idle(30, 1'b1, 6);

    // Reset mid-HOLD with a pending request.
    step(1'b0, 4'b0100, 1'b1, 6);
    idle(5, 1'b1, 6);
    step(1'b0, 4'b1000, 1'b1, 6);
    step(1'b1, '0, 1'b1, 6);
    chk("t6_busy", arb_if.busy, 1'b0);
    chk("t6_pend", arb_if.pend, '0);
    idle(4, 1'b1, 6);

    // H=0: back-to-back every 2 cycles.
    step(1'b0, 4'b0011, 1'b1, 0);
    idle(6, 1'b1, 0);

    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(29) == 0) en = ~en;
      r = ($urandom_range(199) == 0);
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(5) == 0);
      step(r, req, en, int'($urandom_range(9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
